// File: rtl/mult_seq_32_if.sv
// Request/response bundle for the sequential multiplier.
// The master drives the request (start, a, b). The slave returns the status
// (busy, done) and the result (p, hi_nz).
interface mult_seq_32_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;
  logic               hi_nz;

  modport master (output start, a, b, input busy, done, p, hi_nz);
  modport slave  (input start, a, b, output busy, done, p, hi_nz);
endinterface

// File: rtl/mult_seq_32.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock.
// Optional feature: define MULT_SEQ_EARLY_EXIT_EN to end RUN as soon as the
// remaining multiplier bits are all zero. Without it, RUN always lasts WIDTH cycles.
module mult_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mult_seq_32_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_p;
  logic                 r_hi_nz;
  logic [2*WIDTH-1:0]   w_acc_sum;
  logic                 w_load;
  logic                 w_last;
  logic                 w_busy;
  logic                 w_done;

  // Accumulator value after the current iteration (carry out discarded).
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  // A new request is accepted only while not busy: in IDLE, or in DONE.
  assign w_load = bus.start && (r_state != RUN);

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Stop after the iteration that shifts out the last set multiplier bit.
  assign w_last = (r_count == LAST_ITER) || (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_last = (r_count == LAST_ITER);
`endif

  // Register the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Compute the next state and the status outputs. Busy and done are decoded
  // from the state, so reset clears them without waiting for a clock edge.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_state_next = RUN;
      RUN: begin
        w_busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = bus.start ? RUN : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: latch the operands on accept, shift and add during RUN,
  // and capture the result on the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_p      <= '0;
      r_hi_nz  <= 1'b0;
    end else if (w_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, bus.a};
      r_mplier <= bus.b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + CW'(1);
      if (w_last) begin
        r_p     <= w_acc_sum;
        r_hi_nz <= |w_acc_sum[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.busy  = w_busy;
  assign bus.done  = w_done;
  assign bus.p     = r_p;
  assign bus.hi_nz = r_hi_nz;

endmodule

// File: tb/tb_mult_seq_32.sv
// Directed testbench for mult_seq_32. Expected latencies follow
// MULT_SEQ_EARLY_EXIT_EN when that macro is defined for the build.
module tb_mult_seq_32;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mult_seq_32_if #(.WIDTH(32)) bus ();

  mult_seq_32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected RUN length for multiplier value bv.
  function automatic int lenof(input logic [31:0] bv);
    int n;
    n = 32;
`ifdef MULT_SEQ_EARLY_EXIT_EN
    n = 1;
    for (int i = 0; i < 32; i++) if (bv[i]) n = i + 1;
`endif
    return n;
  endfunction

  // Runs one operation. If inj >= 0, a second start (a=2, b=2) is raised
  // inj cycles into RUN and must be ignored.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [63:0] ep, input logic eh, input int inj,
                        input string tag);
    int k;
    int bc;
    logic moved;
    logic [63:0] p0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0; bc = 0; moved = 1'b0; p0 = bus.p;
    while (!bus.done && k < 200) begin
      if (bus.busy) bc++;
      if (bus.p !== p0) moved = 1'b1;
      if (k == inj) begin
        bus.start = 1'b1; bus.a = 32'd2; bus.b = 32'd2;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, 64'(k), 64'(lenof(tb_v)));
    chk({tag, "_busy"}, 64'(bc), 64'(lenof(tb_v)));
    chk({tag, "_stable"}, {63'd0, moved}, 64'd0);
    chk({tag, "_p"}, bus.p, ep);
    chk({tag, "_hinz"}, {63'd0, bus.hi_nz}, {63'd0, eh});
    chk({tag, "_dbusy"}, {63'd0, bus.busy}, 64'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    chk({tag, "_hold"}, bus.p, ep);
    $display("op %s a=%h b=%h p=%h hi_nz=%b cycles=%0d", tag, ta, tb_v, bus.p, bus.hi_nz, k);
  endtask

  initial begin
    int m;
    int ndone;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #1;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_p", bus.p, 64'd0);
    chk("rst_hinz", {63'd0, bus.hi_nz}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(32'd3, 32'd5, 64'd15, 1'b0, -1, "r025");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b1, -1, "r026");
    run_op(32'd7, 32'd9, 64'd63, 1'b0, (lenof(32'd9) > 10) ? 10 : 1, "r027");
    run_op(32'd0, 32'h1234, 64'd0, 1'b0, -1, "a_zero");
    run_op(32'hFFFFFFFF, 32'd1, 64'h00000000FFFFFFFF, 1'b0, -1, "fit");
    run_op(32'h10000, 32'h10000, 64'h0000000100000000, 1'b1, -1, "hi_edge");
    run_op(32'd7, 32'd5, 64'd35, 1'b0, -1, "r030a");
    run_op(32'd123, 32'd0, 64'd0, 1'b0, -1, "r030b");

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'd4; bus.b = 32'd4;
    m = 0;
    @(negedge clk);
    while (!bus.done && m < 200) begin
      @(negedge clk);
      m++;
    end
    chk("b2b_first_p", bus.p, 64'd16);
    chk("b2b_first_done", {63'd0, bus.done}, 64'd1);
    bus.a = 32'd5; bus.b = 32'd5;
    @(negedge clk);
    chk("b2b_nogap", {62'd0, bus.busy, bus.done}, 64'd2);
    bus.start = 1'b0;
    m = 1;
    while (!bus.done && m < 200) begin
      @(negedge clk);
      m++;
    end
    chk("b2b_lat", 64'(m), 64'(lenof(32'd5) + 1));
    chk("b2b_second_p", bus.p, 64'd25);
    $display("op b2b a=5 b=5 p=%h cycles=%0d", bus.p, m);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h12345678; bus.b = 32'h10;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {63'd0, bus.busy}, 64'd0);
    chk("arst_done", {63'd0, bus.done}, 64'd0);
    chk("arst_p", bus.p, 64'd0);
    chk("arst_hinz", {63'd0, bus.hi_nz}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("arst_nodone", 64'(ndone), 64'd0);
    $display("op reset_abort a=12345678 b=10 p=%h", bus.p);
    run_op(32'd6, 32'd7, 64'd42, 1'b0, -1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
